// File: rtl/pulse_train_generator_pkg.sv
// Shared types for the pulse train generator: FSM state encoding.
package pulse_train_generator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } pg_state_t;

    localparam int PG_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/pulse_train_generator_if.sv
// Request/status bundle between a pulse train requester (master) and the generator (slave).
interface pulse_train_generator_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] hi_len;
    logic [CNT_W-1:0] lo_len;
    logic [CNT_W-1:0] num_pulses;
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, hi_len, lo_len, num_pulses,
        input  out, busy, done
    );

    modport slave (
        input  start, abort, hi_len, lo_len, num_pulses,
        output out, busy, done
    );
endinterface

// File: rtl/pulse_train_generator_cnt.sv
// Saturating down-counter with synchronous load; flags when the count is zero.
module pulse_train_generator_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pulse_train_generator.sv
// Emits num_pulses pulses of hi_len cycles separated by lo_len-cycle gaps, then a done strobe.
module pulse_train_generator
    import pulse_train_generator_pkg::*;
#(
    parameter int CNT_W = PG_CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    pulse_train_generator_if.slave  bus
);
    pg_state_t        state_q, state_d;
    logic [CNT_W-1:0] hi_m1_q, hi_m1_d;
    logic [CNT_W-1:0] lo_m1_q, lo_m1_d;

    logic             ph_load, ph_dec, ph_zero;
    logic [CNT_W-1:0] ph_val;
    logic             pc_load, pc_dec, pc_zero;
    logic [CNT_W-1:0] pc_val;

    // Counters hold length-1, so a zero length clamps to one cycle and the
    // maximum length loads without overflow.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : (len - 1'b1);
    endfunction

    always_comb begin
        state_d = state_q;
        hi_m1_d = hi_m1_q;
        lo_m1_d = lo_m1_q;
        ph_load = 1'b0;
        ph_val  = hi_m1_q;
        ph_dec  = 1'b0;
        pc_load = 1'b0;
        pc_val  = len_m1(bus.num_pulses);
        pc_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    hi_m1_d = len_m1(bus.hi_len);
                    lo_m1_d = len_m1(bus.lo_len);
                    ph_load = 1'b1;
                    ph_val  = len_m1(bus.hi_len);
                    pc_load = 1'b1;
                    state_d = (bus.num_pulses != '0) ? HIGH : DONE;
                end
            end
            HIGH: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (ph_zero) begin
                    pc_dec = 1'b1;
                    if (pc_zero) begin
                        state_d = DONE;
                    end else begin
                        ph_load = 1'b1;
                        ph_val  = lo_m1_q;
                        state_d = LOW;
                    end
                end else begin
                    ph_dec = 1'b1;
                end
            end
            LOW: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (ph_zero) begin
                    ph_load = 1'b1;
                    ph_val  = hi_m1_q;
                    state_d = HIGH;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_m1_q <= '0;
            lo_m1_q <= '0;
        end else begin
            state_q <= state_d;
            hi_m1_q <= hi_m1_d;
            lo_m1_q <= lo_m1_d;
        end
    end

    pulse_train_generator_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .dec_i      (ph_dec),
        .zero_o     (ph_zero)
    );

    // Holds pulses remaining after the current one; zero marks the last pulse.
    pulse_train_generator_cnt #(.CNT_W(CNT_W)) u_pulse_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (pc_val),
        .dec_i      (pc_dec),
        .zero_o     (pc_zero)
    );

    assign bus.out  = (state_q == HIGH);
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: table of train shapes, randomized trains vs a waveform model, corner sequences.
module tb_pulse_train_generator;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pulse_train_generator_if #(.CNT_W(W)) bus_if ();

    pulse_train_generator #(.CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];   // {out, busy, done} per busy cycle

    typedef struct {
        int hi; int lo; int n;
        int exp_busy; int exp_high; int exp_rises; int exp_first_out;
    } row_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected waveform built from the pulse/gap/done description.
    task automatic build_exp(input int h, input int l, input int n);
        int he, le;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        exp_q.delete();
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < he; k++) exp_q.push_back(3'b110);
            if (p < n - 1)
                for (int k = 0; k < le; k++) exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b011);
    endtask

    task automatic set_inputs(input int h, input int l, input int n);
        bus_if.hi_len     = W'(h);
        bus_if.lo_len     = W'(l);
        bus_if.num_pulses = W'(n);
    endtask

    task automatic run_row(input row_t r, input int idx);
        int busy_cnt, high, rises, dones, guard, first_out;
        logic prev;
        busy_cnt = 0; high = 0; rises = 0; dones = 0; guard = 0; prev = 1'b0;
        set_inputs(r.hi, r.lo, r.n);
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        first_out = int'(bus_if.out);
        while (bus_if.busy && guard < 3000) begin
            busy_cnt++;
            if (bus_if.out) high++;
            if (bus_if.out && !prev) rises++;
            if (bus_if.done) dones++;
            prev = bus_if.out;
            guard++;
            step();
        end
        chk($sformatf("row%0d_timeout", idx), int'(guard >= 3000), 0);
        chk($sformatf("row%0d_first_out", idx), first_out, r.exp_first_out);
        chk($sformatf("row%0d_busy_cycles", idx), busy_cnt, r.exp_busy);
        chk($sformatf("row%0d_high_cycles", idx), high, r.exp_high);
        chk($sformatf("row%0d_rises", idx), rises, r.exp_rises);
        chk($sformatf("row%0d_done_count", idx), dones, 1);
    endtask

    // Cycle-exact comparison against the model; optional mid-train disturbance
    // of start and the length inputs, which must not affect the running train.
    task automatic model_train(input int h, input int l, input int n, input bit perturb, input string tag);
        build_exp(h, l, n);
        set_inputs(h, l, n);
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_c%0d", tag, i), int'({bus_if.out, bus_if.busy, bus_if.done}), int'(exp_q[i]));
            if (perturb) begin
                bus_if.start = 1'($urandom_range(0, 1));
                set_inputs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            end
            step();
        end
        bus_if.start = 1'b0;
        chk({tag, "_idle_after"}, int'({bus_if.out, bus_if.busy, bus_if.done}), 0);
        step();
    endtask

    row_t rows[8];

    initial begin
        rows[0] = '{hi:1,   lo:1,   n:3, exp_busy:6,   exp_high:3,   exp_rises:3, exp_first_out:1};
        rows[1] = '{hi:1,   lo:2,   n:2, exp_busy:5,   exp_high:2,   exp_rises:2, exp_first_out:1};
        rows[2] = '{hi:0,   lo:5,   n:0, exp_busy:1,   exp_high:0,   exp_rises:0, exp_first_out:0};
        rows[3] = '{hi:0,   lo:0,   n:1, exp_busy:2,   exp_high:1,   exp_rises:1, exp_first_out:1};
        rows[4] = '{hi:3,   lo:2,   n:2, exp_busy:9,   exp_high:6,   exp_rises:2, exp_first_out:1};
        rows[5] = '{hi:255, lo:1,   n:1, exp_busy:256, exp_high:255, exp_rises:1, exp_first_out:1};
        rows[6] = '{hi:2,   lo:255, n:2, exp_busy:260, exp_high:4,   exp_rises:2, exp_first_out:1};
        rows[7] = '{hi:1,   lo:0,   n:4, exp_busy:8,   exp_high:4,   exp_rises:4, exp_first_out:1};

        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        set_inputs(0, 0, 0);

        #3;
        chk("reset_outputs", int'({bus_if.out, bus_if.busy, bus_if.done}), 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_reset_idle", int'({bus_if.out, bus_if.busy, bus_if.done}), 0);

        for (int i = 0; i < 8; i++) begin
            run_row(rows[i], i);
            step();
        end

        // Abort during the second HIGH cycle of a hi=4 train.
        set_inputs(4, 1, 2);
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        chk("abort_high1_out", int'(bus_if.out), 1);
        step();
        chk("abort_high2_out", int'(bus_if.out), 1);
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        chk("abort_next_outputs", int'({bus_if.out, bus_if.busy, bus_if.done}), 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (bus_if.busy || bus_if.done) seen++;
                step();
            end
            chk("abort_stays_idle", seen, 0);
        end

        // Abort beats start in IDLE.
        set_inputs(2, 2, 2);
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        step();
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        chk("abort_blocks_start", int'(bus_if.busy), 0);
        step();

        // Start held high: a new train begins only once busy has dropped.
        set_inputs(1, 1, 1);
        bus_if.start = 1'b1;
        step();
        chk("held_c1", int'({bus_if.out, bus_if.busy, bus_if.done}), 3'b110);
        step();
        chk("held_c2", int'({bus_if.out, bus_if.busy, bus_if.done}), 3'b011);
        step();
        chk("held_idle_gap", int'({bus_if.out, bus_if.busy, bus_if.done}), 0);
        step();
        chk("held_restart", int'({bus_if.out, bus_if.busy, bus_if.done}), 3'b110);
        bus_if.start = 1'b0;
        begin
            int guard;
            guard = 0;
            while (bus_if.busy && guard < 50) begin
                guard++;
                step();
            end
            chk("held_drain_timeout", int'(guard >= 50), 0);
        end
        step();

        // Asynchronous reset in the middle of a LOW phase.
        set_inputs(2, 5, 2);
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        step();
        chk("rst_mid_low_in_low", int'({bus_if.out, bus_if.busy, bus_if.done}), 3'b010);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", int'({bus_if.out, bus_if.busy, bus_if.done}), 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_after_release", int'(bus_if.busy), 0);
        model_train(1, 1, 2, 1'b0, "recover");

        // Randomized trains, half of them disturbed mid-train.
        for (int t = 0; t < 40; t++) begin
            model_train($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 5),
                        (t % 2) == 1, $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
